ikbd_spi_bridge: RTL and testbench
==================================

# ikbd_spi_bridge

Upstream/downstream companion of the keyboard ACIA: an SPI slave in the `clk` domain that carries IKBD traffic between the IO controller and the ACIA. Bytes written by the IO controller are presented as `ikbd_data_in` with an `ikbd_strobe_in` pulse. Bytes queued by the CPU in the ACIA output FIFO are returned over SPI and acknowledged with an `ikbd_strobe_out` pulse. Sits between the top-level SPI pins and the ACIA IKBD ports.

## Interface
- CMD_IKBD_IN, 8'h02, command byte: subsequent bytes go to the ACIA
- CMD_IKBD_OUT, 8'h03, command byte: return status byte then data byte
- STROBE_LEN, 2, strobe pulse width in `clk` cycles (≥1)

- clk  in  1  system clock (8 MHz)
- reset  in  1  synchronous, active-high
- spi_sck  in  1  SPI clock, mode 0, async to `clk`
- spi_ss  in  1  slave select, active low, async
- spi_mosi  in  1  serial data in, MSB first
- spi_miso  out  1  serial data out, MSB first
- ikbd_strobe_in  out  1  byte-valid pulse to ACIA
- ikbd_data_in  out  8  byte to ACIA, held until next byte
- ikbd_data_out_available  in  1  ACIA output FIFO non-empty
- ikbd_data_out  in  8  ACIA output FIFO head
- ikbd_strobe_out  out  1  pop pulse to ACIA output FIFO

## Operation
- `spi_sck`, `spi_ss` and `spi_mosi` pass through 2-flop synchronizers. Edges are detected from the synchronized `spi_sck` (registered previous value).
- `spi_ss` high (synchronized):
  - 3-bit counter `bitcnt` = 0.
  - FSM → IDLE.
  - MISO shift register cleared.
- Rising sck edge with `spi_ss` low:
  - rx shift ← {rx[6:0], mosi}.
  - `bitcnt` += 1, wrapping 7→0. A wrap completes a byte.
- Falling sck edge with `bitcnt` ≠ 0: tx shift ← {tx[6:0], 0}. `spi_miso` = tx[7].
- FSM states: IDLE, CMD, IN, OUT_STAT, OUT_DATA, IGNORE.
  - IDLE → CMD when `spi_ss` goes low.
  - CMD, byte complete:
    - == CMD_IKBD_IN → IN.
    - == CMD_IKBD_OUT → OUT_STAT. Latch `avail` = `ikbd_data_out_available`. tx ← {7'b0, avail}.
    - other → IGNORE.
  - IN, byte complete: `ikbd_data_in` ← byte. Start `ikbd_strobe_in` pulse. Stay in IN, so any number of bytes per transfer.
  - OUT_STAT, byte complete: tx ← `avail` ? `ikbd_data_out` : 8'h00. → OUT_DATA.
  - OUT_DATA, byte complete: if `avail`, start `ikbd_strobe_out` pulse. → IGNORE.
  - IGNORE: bytes discarded, MISO shifts zeros, until `spi_ss` high.
- Strobe pulses: high for exactly STROBE_LEN cycles via a down-counter. A pulse already started completes even if `spi_ss` rises or the transfer ends.
- Boundaries:
  - `spi_ss` rising mid-byte: partial byte discarded, no strobe.
  - Zero data bytes after CMD_IKBD_IN: no strobe.
  - `avail` = 0: data byte reads 8'h00, no pop.
  - Availability changing after the latch is ignored for that transfer.
  - No overflow check toward the ACIA input FIFO; the IO controller paces writes.
- Reset mid-transfer: all state cleared, FSM IDLE, pulses aborted. Resumes at the next `spi_ss` low.
- Reset values: `spi_miso`=0, `ikbd_strobe_in`=0, `ikbd_data_in`=8'h00, `ikbd_strobe_out`=0.

## Timing
- MOSI sample point: 3 `clk` after the pin sck rise (2 sync + 1 edge register).
- MISO update: 3 `clk` after the pin sck fall.
- Requirement: `spi_sck` high and low phases each ≥ 4 `clk` (SPI ≤ 1 MHz at 8 MHz `clk`).
- `ikbd_strobe_in` rises 1 `clk` after the 8th rising edge is detected. `ikbd_data_in` is valid in the same cycle the strobe rises.
- `ikbd_strobe_out` rises 1 `clk` after the 8th rising edge of the data byte is detected.
- The status byte MSB is on `spi_miso` from 1 `clk` after the command completes. The end-of-byte falling edge does not shift (`bitcnt` = 0).
- Minimum byte spacing is 64 `clk`, which is greater than STROBE_LEN. Pulses never overlap.

## Structure
- Package `ikbd_spi_pkg`: command constants, FSM state enum, default STROBE_LEN.
- Sub-module `spi_slave_byte`:
  - Contains the synchronizers, edge detect, `bitcnt`, rx/tx shift registers and the `byte_done` pulse.
  - Provides a `tx_load` input and a `tx_byte` input.
  - Drives `spi_miso`.
- Top level: command FSM, `avail` latch, strobe counters.

## Test plan
- Reset with no SPI activity → all outputs 0 and `ikbd_data_in`=00 for 100 cycles.
- SS low; send 02, 1C, 9C; SS high → two pulses of 2 `clk`; `ikbd_data_in`=1C at the first, 9C at the second; no `ikbd_strobe_out`.
- `available`=1, `ikbd_data_out`=A5; send 03, 00, 00 → MISO returns 01 then A5; exactly one `ikbd_strobe_out` pulse after the 3rd byte.
- `available`=0; send 03, 00, 00 → MISO returns 00 then 00; no `ikbd_strobe_out`.
- Send 02, then 5 bits of 0x3F, then SS high → no `ikbd_strobe_in`. Next transfer 02, 3F → a single strobe with data 3F.
- Assert reset mid-byte during a 03 transfer → no `ikbd_strobe_out`, MISO 0; the following 03 transfer behaves normally.

Source files
------------

// File: rtl/ikbd_spi_bridge_pkg.sv
// Shared constants and types for the IKBD SPI bridge: command codes,
// command FSM states and the default strobe width.
package ikbd_spi_pkg;

  localparam logic [7:0] CMD_IKBD_IN    = 8'h02;
  localparam logic [7:0] CMD_IKBD_OUT   = 8'h03;
  localparam int         STROBE_LEN_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_IN,
    ST_OUT_STAT,
    ST_OUT_DATA,
    ST_IGNORE
  } state_e;

  // Status byte returned after CMD_IKBD_OUT: bit 0 flags a waiting byte.
  function automatic logic [7:0] status_byte(input logic avail);
    return {7'b0, avail};
  endfunction

endpackage

// File: rtl/ikbd_spi_bridge_spi_slave_byte.sv
// Mode-0 SPI slave byte engine: pin synchronizers, sck edge detect, bit
// counter, rx/tx shift registers and a one-cycle byte_done strobe.
module spi_slave_byte (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       ss_active_o,
  output logic       ss_fall_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sck_prev_q;
  logic       ss_prev_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall;

  assign sck_s    = sck_sync_q[1];
  assign ss_s     = ss_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // The select synchronizer resets to "low" so a transfer already running
  // when reset releases is not mistaken for a new one; it waits for ss high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= 2'b00;
      ss_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      bitcnt_q    <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck_i};
      ss_sync_q   <= {ss_sync_q[0], spi_ss_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    if (ss_s) begin
      bitcnt_d = 3'd0;
      tx_d     = 8'h00;
    end else begin
      if (sck_rise) begin
        rx_d     = {rx_q[6:0], mosi_s};
        bitcnt_d = bitcnt_q + 3'd1;
      end
      // The end-of-byte falling edge (bitcnt back at 0) keeps the MSB just loaded.
      if (sck_fall && (bitcnt_q != 3'd0)) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
      if (tx_load_i) begin
        tx_d = tx_byte_i;
      end
    end
  end

  assign spi_miso_o  = tx_q[7];
  assign ss_active_o = ~ss_s;
  assign ss_fall_o   = ~ss_s & ss_prev_q;
  assign byte_done_o = ~ss_s & sck_rise & (bitcnt_q == 3'd7);
  assign rx_byte_o   = {rx_q[6:0], mosi_s};

endmodule

// File: rtl/ikbd_spi_bridge.sv
// IKBD SPI bridge: command FSM on top of the SPI byte engine, forwarding
// IO-controller bytes to the ACIA and returning ACIA output bytes over SPI.
module ikbd_spi_bridge
  import ikbd_spi_pkg::*;
#(
  parameter int STROBE_LEN = STROBE_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       ikbd_strobe_in,
  output logic [7:0] ikbd_data_in,
  input  logic       ikbd_data_out_available,
  input  logic [7:0] ikbd_data_out,
  output logic       ikbd_strobe_out
);

  localparam int CW      = $clog2(STROBE_LEN + 1);
  localparam int STB_IN  = 0;
  localparam int STB_OUT = 1;

  state_e     state_q, state_d;
  logic       avail_q, avail_d;
  logic [7:0] data_in_q, data_in_d;

  logic       tx_load;
  logic [7:0] tx_byte;
  logic       ss_active, ss_fall, byte_done;
  logic [7:0] rx_byte;
  logic [1:0] strobe_start;
  logic [1:0] strobe_active;

  spi_slave_byte u_spi (
    .clk         (clk),
    .reset       (reset),
    .spi_sck_i   (spi_sck),
    .spi_ss_i    (spi_ss),
    .spi_mosi_i  (spi_mosi),
    .spi_miso_o  (spi_miso),
    .tx_load_i   (tx_load),
    .tx_byte_i   (tx_byte),
    .ss_active_o (ss_active),
    .ss_fall_o   (ss_fall),
    .byte_done_o (byte_done),
    .rx_byte_o   (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      avail_q   <= 1'b0;
      data_in_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      avail_q   <= avail_d;
      data_in_q <= data_in_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ss_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ss_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_IKBD_IN)       state_d = ST_IN;
            else if (rx_byte == CMD_IKBD_OUT) state_d = ST_OUT_STAT;
            else                              state_d = ST_IGNORE;
          end
        end
        ST_OUT_STAT: if (byte_done) state_d = ST_OUT_DATA;
        ST_OUT_DATA: if (byte_done) state_d = ST_IGNORE;
        default: state_d = state_q;
      endcase
    end
  end

  // Every completed byte reloads tx, so bytes without a reply shift zeros.
  always_comb begin
    tx_load      = 1'b0;
    tx_byte      = 8'h00;
    avail_d      = avail_q;
    data_in_d    = data_in_q;
    strobe_start = 2'b00;
    if (byte_done) begin
      tx_load = 1'b1;
      case (state_q)
        ST_CMD: begin
          if (rx_byte == CMD_IKBD_OUT) begin
            avail_d = ikbd_data_out_available;
            tx_byte = status_byte(ikbd_data_out_available);
          end
        end
        ST_IN: begin
          data_in_d            = rx_byte;
          strobe_start[STB_IN] = 1'b1;
        end
        ST_OUT_STAT: tx_byte = avail_q ? ikbd_data_out : 8'h00;
        ST_OUT_DATA: strobe_start[STB_OUT] = avail_q;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  // Pulse generators run independently of the transfer so a started pulse
  // always completes its full width.
  for (genvar gi = 0; gi < 2; gi++) begin : g_strobe
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (strobe_start[gi])     cnt_d = CW'(STROBE_LEN);
      else if (cnt_q != '0)     cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign strobe_active[gi] = (cnt_q != '0);
  end

  assign ikbd_strobe_in  = strobe_active[STB_IN];
  assign ikbd_strobe_out = strobe_active[STB_OUT];
  assign ikbd_data_in    = data_in_q;

endmodule

// File: tb/tb_ikbd_spi_bridge.sv
// Scoreboard bench for ikbd_spi_bridge: drives SPI transfers as a mode-0
// master and checks MISO bytes and ACIA strobes against queued expectations.
module tb_ikbd_spi_bridge;
  import ikbd_spi_pkg::*;

  localparam int STROBE_LEN = 2;
  localparam int HALF       = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       ikbd_strobe_in;
  logic [7:0] ikbd_data_in;
  logic       ikbd_data_out_available = 1'b0;
  logic [7:0] ikbd_data_out = 8'h00;
  logic       ikbd_strobe_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_in_q[$];
  logic [7:0] exp_miso_q[$];
  int         exp_out_q[$];

  int   sin_w = 0;
  int   sout_w = 0;
  logic sin_prev = 1'b0;
  logic sout_prev = 1'b0;

  ikbd_spi_bridge #(.STROBE_LEN(STROBE_LEN)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .spi_sck                 (spi_sck),
    .spi_ss                  (spi_ss),
    .spi_mosi                (spi_mosi),
    .spi_miso                (spi_miso),
    .ikbd_strobe_in          (ikbd_strobe_in),
    .ikbd_data_in            (ikbd_data_in),
    .ikbd_data_out_available (ikbd_data_out_available),
    .ikbd_data_out           (ikbd_data_out),
    .ikbd_strobe_out         (ikbd_strobe_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      wait_clk(HALF);
      spi_sck = 1'b1;
      rx = {rx[6:0], spi_miso};
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_xfer_byte(input logic [7:0] b, input logic [7:0] exp_rx);
    logic [7:0] rx;
    logic [7:0] e;
    exp_miso_q.push_back(exp_rx);
    spi_bits(b, 8, rx);
    e = exp_miso_q.pop_front();
    $display("spi byte mosi=%02h miso=%02h exp=%02h", b, rx, e);
    check_eq("miso_byte", {24'h0, rx}, {24'h0, e});
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_end();
    wait_clk(HALF);
    spi_ss = 1'b1;
    wait_clk(20);
  endtask

  // Strobe monitors: each rising edge consumes one expectation, each falling
  // edge checks the pulse width.
  always @(negedge clk) begin
    if (ikbd_strobe_in === 1'b1) begin
      if (sin_prev !== 1'b1) begin
        if (exp_in_q.size() == 0) begin
          check_eq("in_unexpected", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_in_q.pop_front();
          $display("strobe_in data=%02h exp=%02h", ikbd_data_in, e);
          check_eq("in_data", {24'h0, ikbd_data_in}, {24'h0, e});
        end
      end
      sin_w++;
    end else if (sin_prev === 1'b1) begin
      check_eq("in_width", sin_w, STROBE_LEN);
      sin_w = 0;
    end
    sin_prev = ikbd_strobe_in;

    if (ikbd_strobe_out === 1'b1) begin
      if (sout_prev !== 1'b1) begin
        $display("strobe_out pulse");
        if (exp_out_q.size() == 0) check_eq("out_unexpected", 32'd1, 32'd0);
        else void'(exp_out_q.pop_front());
      end
      sout_w++;
    end else if (sout_prev === 1'b1) begin
      check_eq("out_width", sout_w, STROBE_LEN);
      sout_w = 0;
    end
    sout_prev = ikbd_strobe_out;
  end

  initial begin
    logic [7:0] rx;

    wait_clk(5);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("reset_idle", {21'h0, spi_miso, ikbd_strobe_in, ikbd_strobe_out, ikbd_data_in}, 32'h0);
    end

    // Two bytes forwarded to the ACIA in one transfer.
    ss_begin();
    spi_xfer_byte(CMD_IKBD_IN, 8'h00);
    exp_in_q.push_back(8'h1C);
    spi_xfer_byte(8'h1C, 8'h00);
    exp_in_q.push_back(8'h9C);
    spi_xfer_byte(8'h9C, 8'h00);
    ss_end();

    // Byte available; availability dropping after the latch is ignored.
    ikbd_data_out_available = 1'b1;
    ikbd_data_out = 8'hA5;
    ss_begin();
    spi_xfer_byte(CMD_IKBD_OUT, 8'h00);
    ikbd_data_out_available = 1'b0;
    spi_xfer_byte(8'h00, 8'h01);
    exp_out_q.push_back(1);
    spi_xfer_byte(8'h00, 8'hA5);
    ss_end();

    // Nothing available; availability rising after the latch is ignored.
    ikbd_data_out_available = 1'b0;
    ss_begin();
    spi_xfer_byte(CMD_IKBD_OUT, 8'h00);
    ikbd_data_out_available = 1'b1;
    ikbd_data_out = 8'h5A;
    spi_xfer_byte(8'h00, 8'h00);
    spi_xfer_byte(8'h00, 8'h00);
    ss_end();
    ikbd_data_out_available = 1'b0;

    // Partial byte then a clean retry.
    ss_begin();
    spi_xfer_byte(CMD_IKBD_IN, 8'h00);
    spi_bits(8'h3F, 5, rx);
    ss_end();
    ss_begin();
    spi_xfer_byte(CMD_IKBD_IN, 8'h00);
    exp_in_q.push_back(8'h3F);
    spi_xfer_byte(8'h3F, 8'h00);
    ss_end();
    check_eq("in_hold", {24'h0, ikbd_data_in}, 32'h3F);

    // Reset in the middle of the status byte of an OUT transfer.
    ikbd_data_out_available = 1'b1;
    ikbd_data_out = 8'hA5;
    ss_begin();
    spi_xfer_byte(CMD_IKBD_OUT, 8'h00);
    spi_bits(8'h00, 4, rx);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    check_eq("rst_mid_outputs", {21'h0, spi_miso, ikbd_strobe_in, ikbd_strobe_out, ikbd_data_in}, 32'h0);
    ss_end();
    check_eq("rst_mid_miso", {31'h0, spi_miso}, 32'h0);

    ss_begin();
    spi_xfer_byte(CMD_IKBD_OUT, 8'h00);
    spi_xfer_byte(8'h00, 8'h01);
    exp_out_q.push_back(1);
    spi_xfer_byte(8'h00, 8'hA5);
    ss_end();
    ikbd_data_out_available = 1'b0;

    wait_clk(20);
    check_eq("in_pending", exp_in_q.size(), 32'd0);
    check_eq("out_pending", exp_out_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
